// File: rtl/prbs7_rx_checker_pkg.sv
// Shared PRBS7 (x^7 + x^6 + 1) definitions for the lane generator and receive checker.
package prbs_pkg;

  localparam int PRBS_ORDER = 7;
  localparam int PRBS_TAP_A = 7;
  localparam int PRBS_TAP_B = 6;
  localparam int POP_MAX_W  = 80;
  localparam int POP_CNT_W  = 7;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } prbs_state_e;

  function automatic logic [POP_CNT_W-1:0] popcount(input logic [POP_MAX_W-1:0] v);
    logic [POP_CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      c = c + {{(POP_CNT_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/prbs7_rx_checker_if.sv
// Word/statistics bundle between a receive lane and its PRBS7 checker.
interface prbs7_rx_checker_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 32
) ();

  logic             en_i;
  logic [WIDTH-1:0] rx_data_i;
  logic             clr_i;
  logic             lock_o;
  logic             err_o;
  logic [WIDTH-1:0] err_bits_o;
  logic [CNT_W-1:0] err_cnt_o;
  logic [CNT_W-1:0] word_cnt_o;

  modport master (
    output en_i, rx_data_i, clr_i,
    input  lock_o, err_o, err_bits_o, err_cnt_o, word_cnt_o
  );

  modport slave (
    input  en_i, rx_data_i, clr_i,
    output lock_o, err_o, err_bits_o, err_cnt_o, word_cnt_o
  );

endinterface

// File: rtl/prbs7_rx_checker_predict.sv
// Combinational PRBS7 predictor: each bit is the XOR of the bits 7 and 6 positions earlier,
// taken from the received history for the first positions of the word.
module prbs7_predict
  import prbs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [PRBS_ORDER-1:0] i_hist,
  input  logic [WIDTH-1:0]      i_data,
  output logic [WIDTH-1:0]      o_exp
);

  // w_ext[j] is the wire bit at relative time j-7; i_hist[0] is the oldest history bit
  logic [WIDTH:0] w_ext;

  assign w_ext = {i_data[WIDTH-PRBS_ORDER:0], i_hist};

  // Apply the recurrence to every bit position of the word
  always_comb begin
    o_exp = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_exp[i] = w_ext[i + PRBS_ORDER - PRBS_TAP_A] ^ w_ext[i + PRBS_ORDER - PRBS_TAP_B];
    end
  end

endmodule

// File: rtl/prbs7_rx_checker.sv
// Self-synchronising PRBS7 receive checker: search/lock state machine, per-word error mask,
// and saturating bit-error / word counters accumulated while locked.
module prbs7_rx_checker
  import prbs_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LOCK_CNT = 64,
  parameter int LOSS_CNT = 4,
  parameter int CNT_W    = 32
) (
  input logic               rx_clk_i,
  input logic               rx_rst_i,
  prbs7_rx_checker_if.slave bus
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(LOSS_CNT + 1);
  localparam int SUM_W  = CNT_W + POP_CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  prbs_state_e           r_state;
  prbs_state_e           w_state_nxt;
  logic [PRBS_ORDER-1:0] r_hist;
  logic [PRBS_ORDER-1:0] w_hist_nxt;
  logic                  r_prime;
  logic                  w_prime_nxt;
  logic [GOOD_W-1:0]     r_good_cnt;
  logic [GOOD_W-1:0]     w_good_nxt;
  logic [BAD_W-1:0]      r_bad_cnt;
  logic [BAD_W-1:0]      w_bad_nxt;
  logic                  r_err;
  logic                  w_err_nxt;
  logic [WIDTH-1:0]      r_err_bits;
  logic [WIDTH-1:0]      w_err_bits_nxt;
  logic [CNT_W-1:0]      r_err_cnt;
  logic [CNT_W-1:0]      w_err_cnt_nxt;
  logic [CNT_W-1:0]      r_word_cnt;
  logic [CNT_W-1:0]      w_word_cnt_nxt;

  logic [WIDTH-1:0]      w_exp;
  logic [WIDTH-1:0]      w_mism;
  logic                  w_bad;
  logic                  w_word_inc;
  logic [POP_CNT_W-1:0]  w_bits_inc;
  logic [SUM_W-1:0]      w_err_sum;
  logic [SUM_W-1:0]      w_word_sum;

  prbs7_predict #(
    .WIDTH (WIDTH)
  ) u_predict (
    .i_hist (r_hist),
    .i_data (bus.rx_data_i),
    .o_exp  (w_exp)
  );

  // All-zero data is the recurrence's fixed point, so it never counts as good
  assign w_mism = w_exp ^ bus.rx_data_i;
  assign w_bad  = (w_mism != '0) || (bus.rx_data_i == '0);

  // Next-state, history and per-word result for the current qualified word
  always_comb begin
    w_state_nxt    = r_state;
    w_hist_nxt     = r_hist;
    w_prime_nxt    = r_prime;
    w_good_nxt     = r_good_cnt;
    w_bad_nxt      = r_bad_cnt;
    w_err_nxt      = 1'b0;
    w_err_bits_nxt = '0;
    w_word_inc     = 1'b0;
    w_bits_inc     = '0;
    if (bus.en_i) begin
      w_hist_nxt = bus.rx_data_i[WIDTH-1 -: PRBS_ORDER];
      if (!r_prime) begin
        w_prime_nxt = 1'b1;
      end else begin
        w_err_nxt      = (w_mism != '0);
        w_err_bits_nxt = w_mism;
        case (r_state)
          SEARCH: begin
            if (w_bad) begin
              w_good_nxt = '0;
            end else if (r_good_cnt == GOOD_W'(LOCK_CNT - 1)) begin
              w_state_nxt = LOCKED;
              w_good_nxt  = '0;
              w_bad_nxt   = '0;
            end else begin
              w_good_nxt = r_good_cnt + GOOD_W'(1);
            end
          end
          LOCKED: begin
            w_word_inc = 1'b1;
            w_bits_inc = popcount(POP_MAX_W'(w_mism));
            if (!w_bad) begin
              w_bad_nxt = '0;
            end else if (r_bad_cnt == BAD_W'(LOSS_CNT - 1)) begin
              w_state_nxt = SEARCH;
              w_good_nxt  = '0;
              w_bad_nxt   = '0;
              w_prime_nxt = 1'b0;
            end else begin
              w_bad_nxt = r_bad_cnt + BAD_W'(1);
            end
          end
          default: begin
            w_state_nxt = SEARCH;
            w_good_nxt  = '0;
            w_bad_nxt   = '0;
            w_prime_nxt = 1'b0;
          end
        endcase
      end
    end else begin
      w_err_nxt = 1'b0;
    end
  end

  // Saturating statistics; a clear discards any same-cycle increment
  always_comb begin
    w_err_sum  = SUM_W'(r_err_cnt) + SUM_W'(w_bits_inc);
    w_word_sum = SUM_W'(r_word_cnt) + SUM_W'(w_word_inc);
    if (bus.clr_i) begin
      w_err_cnt_nxt  = '0;
      w_word_cnt_nxt = '0;
    end else begin
      if (w_err_sum > SUM_W'(CNT_MAX)) begin
        w_err_cnt_nxt = CNT_MAX;
      end else begin
        w_err_cnt_nxt = w_err_sum[CNT_W-1:0];
      end
      if (w_word_sum > SUM_W'(CNT_MAX)) begin
        w_word_cnt_nxt = CNT_MAX;
      end else begin
        w_word_cnt_nxt = w_word_sum[CNT_W-1:0];
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge rx_clk_i) begin
    if (rx_rst_i) begin
      r_state    <= SEARCH;
      r_hist     <= '0;
      r_prime    <= 1'b0;
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
      r_err      <= 1'b0;
      r_err_bits <= '0;
      r_err_cnt  <= '0;
      r_word_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hist     <= w_hist_nxt;
      r_prime    <= w_prime_nxt;
      r_good_cnt <= w_good_nxt;
      r_bad_cnt  <= w_bad_nxt;
      r_err      <= w_err_nxt;
      r_err_bits <= w_err_bits_nxt;
      r_err_cnt  <= w_err_cnt_nxt;
      r_word_cnt <= w_word_cnt_nxt;
    end
  end

  assign bus.lock_o     = (r_state == LOCKED);
  assign bus.err_o      = r_err;
  assign bus.err_bits_o = r_err_bits;
  assign bus.err_cnt_o  = r_err_cnt;
  assign bus.word_cnt_o = r_word_cnt;

endmodule

// File: tb/tb_prbs7_rx_checker.sv
// Directed + randomized bench for prbs7_rx_checker against a bit-level PRBS7 reference model.
module tb_prbs7_rx_checker;

  localparam int W        = 8;
  localparam int LOCK_N   = 64;
  localparam int LOSS_N   = 4;
  localparam int CW_A     = 32;
  localparam int CW_B     = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         clr;
  logic [W-1:0] data;

  int vectors     = 0;
  int miscompares = 0;

  prbs7_rx_checker_if #(.WIDTH(W), .CNT_W(CW_A)) if_a ();
  prbs7_rx_checker_if #(.WIDTH(W), .CNT_W(CW_B)) if_b ();

  assign if_a.en_i      = en;
  assign if_a.rx_data_i = data;
  assign if_a.clr_i     = clr;
  assign if_b.en_i      = en;
  assign if_b.rx_data_i = data;
  assign if_b.clr_i     = clr;

  prbs7_rx_checker #(.WIDTH(W), .LOCK_CNT(LOCK_N), .LOSS_CNT(LOSS_N), .CNT_W(CW_A)) dut_a (
    .rx_clk_i (clk),
    .rx_rst_i (rst),
    .bus      (if_a)
  );

  prbs7_rx_checker #(.WIDTH(W), .LOCK_CNT(LOCK_N), .LOSS_CNT(LOSS_N), .CNT_W(CW_B)) dut_b (
    .rx_clk_i (clk),
    .rx_rst_i (rst),
    .bus      (if_b)
  );

  always #5 clk = ~clk;

  // transmitter bit history (time order) and receiver reference state
  bit       txq[$];
  bit       rxh[7];
  bit       m_locked;
  bit       m_prime;
  int       m_good;
  int       m_bad;
  longint   m_ecnt;
  longint   m_wcnt;
  bit       m_err;
  logic [W-1:0] m_bits;

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tx_next(output logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      bit nb;
      nb = txq[txq.size()-7] ^ txq[txq.size()-6];
      txq.push_back(nb);
      w[i] = nb;
    end
    while (txq.size() > 7) void'(txq.pop_front());
  endtask

  task automatic model_step(input logic e, input logic [W-1:0] d, input logic c, input logic r);
    bit seq[W+7];
    logic [W-1:0] mism;
    bit bad;
    if (r) begin
      m_locked = 0; m_prime = 0; m_good = 0; m_bad = 0;
      m_ecnt = 0; m_wcnt = 0; m_err = 0; m_bits = '0;
      for (int i = 0; i < 7; i++) rxh[i] = 0;
      return;
    end
    m_err  = 0;
    m_bits = '0;
    if (e) begin
      for (int i = 0; i < 7; i++) seq[i] = rxh[i];
      for (int i = 0; i < W; i++) seq[7+i] = d[i];
      // seq[7+n] holds wire bit n; predicted bit n = bit(n-7) ^ bit(n-6)
      for (int i = 0; i < W; i++) mism[i] = (seq[7+i-7] ^ seq[7+i-6]) ^ d[i];
      for (int i = 0; i < 7; i++) rxh[i] = seq[W+i];
      if (!m_prime) begin
        m_prime = 1;
      end else begin
        bad    = (mism != '0) || (d == '0);
        m_err  = (mism != '0);
        m_bits = mism;
        if (m_locked) begin
          m_wcnt++;
          m_ecnt += $countones(mism);
          if (bad) begin
            m_bad++;
            if (m_bad == LOSS_N) begin
              m_locked = 0; m_good = 0; m_bad = 0; m_prime = 0;
            end
          end else begin
            m_bad = 0;
          end
        end else if (bad) begin
          m_good = 0;
        end else begin
          m_good++;
          if (m_good == LOCK_N) begin
            m_locked = 1; m_good = 0; m_bad = 0;
          end
        end
      end
    end
    if (c) begin
      m_ecnt = 0;
      m_wcnt = 0;
    end
  endtask

  task automatic step(input logic e, input logic [W-1:0] d, input logic c, input logic r);
    en = e; data = d; clr = c; rst = r;
    @(posedge clk);
    #1;
    model_step(e, d, c, r);
    chk("lock_a",  if_a.lock_o,     m_locked);
    chk("err_a",   if_a.err_o,      m_err);
    chk("bits_a",  if_a.err_bits_o, m_bits);
    chk("ecnt_a",  if_a.err_cnt_o,  sat(m_ecnt, CW_A));
    chk("wcnt_a",  if_a.word_cnt_o, sat(m_wcnt, CW_A));
    chk("lock_b",  if_b.lock_o,     m_locked);
    chk("ecnt_b",  if_b.err_cnt_o,  sat(m_ecnt, CW_B));
    chk("wcnt_b",  if_b.word_cnt_o, sat(m_wcnt, CW_B));
  endtask

  task automatic clean(input int n);
    logic [W-1:0] w;
    for (int i = 0; i < n; i++) begin
      tx_next(w);
      step(1'b1, w, 1'b0, 1'b0);
    end
  endtask

  task automatic find_lock(input int limit, output int idx);
    logic [W-1:0] w;
    idx = -1;
    for (int i = 1; i <= limit; i++) begin
      tx_next(w);
      step(1'b1, w, 1'b0, 1'b0);
      if (if_a.lock_o === 1'b1) begin
        idx = i;
        break;
      end
    end
  endtask

  initial begin
    logic [W-1:0] w;
    int           idx;
    int           nvalid;
    bit           seen;
    longint       ec0;

    en = 1'b0; clr = 1'b0; rst = 1'b1; data = '0;
    for (int i = 0; i < 7; i++) txq.push_back(bit'($urandom_range(0, 1)));
    if (txq[0] == 0 && txq[1] == 0 && txq[2] == 0 && txq[3] == 0 &&
        txq[4] == 0 && txq[5] == 0 && txq[6] == 0) txq[0] = 1;

    // reset state
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 8'hA5, 1'b1, 1'b1);
    chk("rst_lock", if_a.lock_o, 64'd0);
    chk("rst_wcnt", if_a.word_cnt_o, 64'd0);

    // clean stream: lock at word 65, nothing counted yet
    find_lock(100, idx);
    chk("lock_idx", idx, 64'd65);
    chk("lock_ecnt", if_a.err_cnt_o, 64'd0);
    clean(20);
    chk("locked_wcnt", if_a.word_cnt_o, 64'd20);

    // single flipped bit 2 spreads to 8'h04 then 8'h03
    ec0 = m_ecnt;
    tx_next(w);
    step(1'b1, w ^ 8'h04, 1'b0, 1'b0);
    chk("flip_err", if_a.err_o, 64'd1);
    chk("flip_bits0", if_a.err_bits_o, 64'h04);
    tx_next(w);
    step(1'b1, w, 1'b0, 1'b0);
    chk("flip_bits1", if_a.err_bits_o, 64'h03);
    chk("flip_ecnt", if_a.err_cnt_o, 64'(ec0 + 3));
    chk("flip_lock", if_a.lock_o, 64'd1);
    clean(10);

    // four consecutive bad words drop lock, then relock after 1 + 64 clean words
    for (int k = 0; k < 4; k++) begin
      tx_next(w);
      step(1'b1, w ^ 8'h01, 1'b0, 1'b0);
      if (k == 2) chk("loss_hold", if_a.lock_o, 64'd1);
      if (k == 3) chk("loss_fall", if_a.lock_o, 64'd0);
    end
    find_lock(100, idx);
    chk("relock_idx", idx, 64'd65);

    // en toggling every cycle: lock after 65 valid words
    step(1'b0, '0, 1'b0, 1'b1);
    nvalid = 0;
    idx = -1;
    for (int i = 0; i < 200 && idx < 0; i++) begin
      if (i % 2 == 0) begin
        tx_next(w);
        step(1'b1, w, 1'b0, 1'b0);
        nvalid++;
      end else begin
        step(1'b0, W'($urandom), 1'b0, 1'b0);
      end
      if (if_a.lock_o === 1'b1) idx = nvalid;
    end
    chk("toggle_idx", idx, 64'd65);
    chk("toggle_ecnt", if_a.err_cnt_o, 64'd0);

    // all-zero data never locks
    step(1'b0, '0, 1'b0, 1'b1);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, '0, 1'b0, 1'b0);
      if (if_a.lock_o !== 1'b0) seen = 1;
    end
    chk("zero_lock", 64'(seen), 64'd0);
    chk("zero_ecnt", if_a.err_cnt_o, 64'd0);

    // saturation of the narrow counters: 30 flips spaced three words apart
    step(1'b0, '0, 1'b0, 1'b1);
    find_lock(100, idx);
    chk("sat_lock_idx", idx, 64'd65);
    clean(5);
    for (int k = 0; k < 30; k++) begin
      tx_next(w);
      step(1'b1, w ^ 8'h04, 1'b0, 1'b0);
      clean(2);
    end
    chk("sat_ecnt_a", if_a.err_cnt_o, 64'd90);
    chk("sat_ecnt_b", if_b.err_cnt_o, 64'd63);
    chk("sat_wcnt_b", if_b.word_cnt_o, 64'd63);
    chk("sat_lock", if_a.lock_o, 64'd1);

    // clear wins over a same-cycle error increment
    tx_next(w);
    step(1'b1, w ^ 8'h10, 1'b1, 1'b0);
    chk("clr_ecnt", if_a.err_cnt_o, 64'd0);
    chk("clr_wcnt", if_a.word_cnt_o, 64'd0);

    // randomized traffic: gaps, sparse bit flips, occasional clears
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        tx_next(w);
        if ($urandom_range(0, 7) == 0) w = w ^ (W'(1) << $urandom_range(0, W-1));
        step(1'b1, w, 1'($urandom_range(0, 39) == 0), 1'b0);
      end else begin
        step(1'b0, W'($urandom), 1'($urandom_range(0, 39) == 0), 1'b0);
      end
    end

    // reset while locked returns every output to zero
    clean(70);
    chk("pre_rst_lock", if_a.lock_o, 64'd1);
    tx_next(w);
    step(1'b1, w ^ 8'h20, 1'b0, 1'b1);
    chk("rst_lock2", if_a.lock_o, 64'd0);
    chk("rst_err2", if_a.err_o, 64'd0);
    chk("rst_bits2", if_a.err_bits_o, 64'd0);
    chk("rst_ecnt2", if_a.err_cnt_o, 64'd0);
    chk("rst_wcnt2", if_a.word_cnt_o, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prbs7_rx_checker.md
Name: prbs7_rx_checker

Overview:
Self-synchronising PRBS7 (x^7+x^6+1) checker for one SERDES receive lane. It sits on the lane's rx_pcs_clkout domain after the Customized PHY RX FIFO and consumes the low WIDTH bits of rx_data_o. It runs a search/lock state machine, flags per-word bit errors, and keeps saturating bit-error and word counters for link bring-up and BER measurement. It is the receive-end counterpart of the lane PRBS7 generator and replaces the bare lock bit with a measurable checker.

Parameters:
WIDTH, 8, parallel word width in bits; legal range 8..80; bit 0 is the first bit on the wire.
LOCK_CNT, 64, consecutive error-free words needed to enter LOCKED (must be >= 1).
LOSS_CNT, 4, consecutive errored words in LOCKED that force SEARCH (must be >= 1).
CNT_W, 32, width of the statistics counters.

Ports:
rx_clk_i  in  1  lane RX PCS clock; the only clock.
rx_rst_i  in  1  synchronous, active-high reset.
en_i  in  1  word qualifier; the word is evaluated only when en_i=1.
rx_data_i  in  WIDTH  received word, LSB first in time.
clr_i  in  1  synchronous clear of err_cnt_o and word_cnt_o; the state machine is unaffected.
lock_o  out  1  1 while the state is LOCKED.
err_o  out  1  pulse: the last evaluated word had >=1 bit error.
err_bits_o  out  WIDTH  per-bit mismatch mask of the last evaluated word.
err_cnt_o  out  CNT_W  saturating count of bit errors seen in LOCKED.
word_cnt_o  out  CNT_W  saturating count of words evaluated in LOCKED.

Behaviour:
- Reset (rx_rst_i=1 at a rx_clk_i edge): state=SEARCH, history=0, prime=0, good_cnt=0, bad_cnt=0. All outputs are 0.
- History: 7-bit register holding the last 7 received bits. It updates on every en_i=1 word from rx_data_i, not from the predicted data.
- Prediction: exp[i] = b[i-7] ^ b[i-6]. Negative indices take bits from the history; other indices take bits of the current received word.
- mism = exp ^ rx_data_i.
- A word is bad if mism != 0, or if rx_data_i == 0. An all-zero word can never occur in PRBS7 for WIDTH >= 7, and zero is a fixed point of the recurrence.
- Priming: the first en_i word after reset, or after entering SEARCH, only loads the history and sets prime=1. It is not judged, err_o stays 0, and no counter moves.
- Latency: a word evaluated at edge n drives err_o, err_bits_o, lock_o and the counters at edge n+1 (one registered stage).
- err_o and err_bits_o are valid for one cycle. They are 0 in any cycle without an evaluated word.
- States:
  - SEARCH: a good word increments good_cnt; a bad word clears it to 0. When good_cnt reaches LOCK_CNT, go to LOCKED and clear bad_cnt. lock_o rises on the same edge as the LOCK_CNT-th good word's result.
  - LOCKED: a bad word increments bad_cnt; a good word clears it. When bad_cnt reaches LOSS_CNT, go to SEARCH with good_cnt=0 and prime=0.
- Counters in LOCKED, including the word that causes loss of lock:
  - word_cnt_o += 1 per evaluated word.
  - err_cnt_o += popcount(mism). An all-zero word with mism=0 adds 0 bits but still counts as bad.
  - Both counters saturate at all-ones and never wrap.
- clr_i has priority over a same-cycle increment; that increment is discarded.
- en_i=0: no state, history or counter change; err_o=0.
- Error spreading: a single flipped wire bit yields 3 mismatches (positions k, k+6, k+7), possibly split across two words.
- Reset mid-operation returns to the reset values on the next edge, regardless of state.

Decomposition:
- Package prbs_pkg holds:
  - state enum {SEARCH, LOCKED};
  - PRBS7 constants: order 7, taps 7 and 6;
  - a popcount function.
- Sub-module prbs7_predict: purely combinational. It takes history[6:0] and data[WIDTH-1:0] and returns exp[WIDTH-1:0]. The lane generator can reuse it.

Test Plan:
- Clean PRBS7 stream from a reference model, en_i=1 continuously after reset -> lock_o rises at the result edge of word 65 (1 priming + 64); err_cnt_o=0; word_cnt_o counts from the first locked word.
- While locked, flip bit 2 of one word (WIDTH=8) -> err_o for that word with err_bits_o=8'h04, next word err_bits_o=8'h03; err_cnt_o += 3; lock_o held.
- While locked, corrupt 4 consecutive words -> lock_o falls on the 4th word's result edge; relock occurs after 1 priming + 64 clean words.
- rx_data_i=0 held with en_i=1 -> lock_o never asserts; err_cnt_o stays 0.
- Clean stream with en_i toggling 1/0 every cycle -> lock_o after 65 valid words; no errors.
- Preload err_cnt_o to all-ones (force), then inject an error -> it stays all-ones. Assert clr_i together with an error -> both counters read 0. Assert rx_rst_i while locked -> all outputs 0 at the next edge.
